// File: rtl/game_controller_event_gen.sv
// Frame-synchronous button debounce and event generator. Define
// GAME_CONTROLLER_AUTOREPEAT_EN to build the auto-repeat logic; otherwise repeat_pulse is 0.

module game_controller_event_gen_lane (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic button,
  output logic new_held,
  output logic held,
  output logic pressed,
  output logic released
);
  logic last_sample;

  // A level only takes effect once it has been seen on two consecutive ticks.
  assign new_held = (button == last_sample) ? button : held;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_sample <= 1'b0;
      held        <= 1'b0;
      pressed     <= 1'b0;
      released    <= 1'b0;
    end else if (tick) begin
      last_sample <= button;
      held        <= new_held;
      pressed     <= new_held & ~held;
      released    <= ~new_held & held;
    end else begin
      pressed     <= 1'b0;
      released    <= 1'b0;
    end
  end
endmodule

module game_controller_event_gen #(
  parameter int                   BIT_WIDTH    = 12,
  parameter logic [BIT_WIDTH-1:0] REPEAT_MASK  = 'h0F0,
  parameter int                   REPEAT_DELAY = 20,
  parameter int                   REPEAT_RATE  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic [BIT_WIDTH-1:0] buttons,
  output logic [BIT_WIDTH-1:0] held,
  output logic [BIT_WIDTH-1:0] pressed,
  output logic [BIT_WIDTH-1:0] released,
  output logic [BIT_WIDTH-1:0] repeat_pulse,
  output logic                 any_event
);
  logic                 vsync_q;
  logic                 tick;
  logic [BIT_WIDTH-1:0] new_held;

  // vsync_q resets high so a vsync already high at release is not a tick.
  always_ff @(posedge clk) begin
    if (reset) vsync_q <= 1'b1;
    else       vsync_q <= vsync;
  end

  assign tick = vsync & ~vsync_q;

  for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_lane
    game_controller_event_gen_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .button   (buttons[i]),
      .new_held (new_held[i]),
      .held     (held[i]),
      .pressed  (pressed[i]),
      .released (released[i])
    );
  end

`ifdef GAME_CONTROLLER_AUTOREPEAT_EN
  logic [7:0]           rcnt;
  logic [7:0]           rcnt_inc;
  logic [7:0]           lim;
  logic                 rphase;
  logic [BIT_WIDTH-1:0] m_new;
  logic [BIT_WIDTH-1:0] m_old;

  assign m_new    = new_held & REPEAT_MASK;
  assign m_old    = held & REPEAT_MASK;
  assign lim      = rphase ? 8'(REPEAT_RATE) : 8'(REPEAT_DELAY);
  assign rcnt_inc = rcnt + 8'd1;

  // Any change to the masked held set restarts the initial delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt         <= 8'd0;
      rphase       <= 1'b0;
      repeat_pulse <= '0;
    end else if (tick) begin
      if (m_new == '0 || m_new != m_old) begin
        rcnt         <= 8'd0;
        rphase       <= 1'b0;
        repeat_pulse <= '0;
      end else if (rcnt_inc == lim) begin
        rcnt         <= 8'd0;
        rphase       <= 1'b1;
        repeat_pulse <= m_new;
      end else begin
        rcnt         <= rcnt_inc;
        repeat_pulse <= '0;
      end
    end else begin
      repeat_pulse <= '0;
    end
  end

  assign any_event = |(pressed | released | repeat_pulse);
`else
  logic unused_repeat_cfg;

  assign unused_repeat_cfg = ^{REPEAT_MASK, REPEAT_DELAY, REPEAT_RATE};
  assign repeat_pulse      = '0;
  assign any_event         = |(pressed | released);
`endif

endmodule

// File: doc/game_controller_event_gen.md
# game_controller_event_gen

Frame-synchronous button event generator placed directly downstream of the SNES game-controller PMOD driver. It samples the driver's 12-bit parallel button word once per video frame and filters out single-frame glitches. It emits debounced held state, one-cycle press/release pulses and optional D-pad auto-repeat pulses for game logic to consume.

## Interface
- `BIT_WIDTH`, 12, width of button word; bit order {b, y, select, start, up, down, left, right, a, x, l, r}, b = MSB.
- `REPEAT_MASK`, 12'h0F0, bits eligible for auto-repeat (default up/down/left/right).
- `REPEAT_DELAY`, 20, frames from press to first repeat; legal 1..255.
- `REPEAT_RATE`, 6, frames between subsequent repeats; legal 1..255.

- `clk` in 1: pixel clock, single clock domain.
- `reset` in 1: synchronous, active-high.
- `vsync` in 1: frame marker from `hvsync_generator`; rising edge = frame tick.
- `buttons` in BIT_WIDTH: driver `data_reg` output, 1 = pressed.
- `held` out BIT_WIDTH: debounced button state.
- `pressed` out BIT_WIDTH: one-cycle pulse per bit on debounced 0→1.
- `released` out BIT_WIDTH: one-cycle pulse per bit on debounced 1→0.
- `repeat_pulse` out BIT_WIDTH: one-cycle auto-repeat pulse, subset of `held & REPEAT_MASK`.
- `any_event` out 1: OR-reduce of `pressed | released | repeat_pulse`, same cycle.

## Operation
- Tick: `tick = vsync & ~vsync_q`, where `vsync_q` is `vsync` registered. Nothing below changes state in non-tick cycles.
- Debounce, per bit on tick: `new_held[i] = buttons[i]` if `buttons[i] == last_sample[i]`, else `held[i]`. Then `last_sample <= buttons`. A value must be seen on two consecutive ticks to take effect.
- On tick: `held <= new_held`, `pressed <= new_held & ~held`, `released <= ~new_held & held`.
- Auto-repeat state:
  - Registers: 8-bit frame counter `rcnt` and phase flag `rphase` (0 = DELAY, 1 = RATE).
  - `m_new = new_held & REPEAT_MASK` and `m_old = held & REPEAT_MASK`.
- Auto-repeat on each tick:
  - If `m_new == 0` or `m_new != m_old`: `rcnt <= 0`, `rphase <= 0`, no repeat.
  - Otherwise let `lim = rphase ? REPEAT_RATE : REPEAT_DELAY`. If `rcnt + 1 == lim`: `repeat_pulse <= m_new`, `rcnt <= 0`, `rphase <= 1`. Else `rcnt <= rcnt + 1`.
- A change in the masked held set restarts the delay. Consequently `pressed` and `repeat_pulse` never coincide for the same bit.
- Non-masked bits never repeat.
- Pulse outputs are 0 in every cycle except the one after a tick.

## Timing
- Reset values: `held`, `pressed`, `released`, `repeat_pulse`, `any_event`, `last_sample`, `rcnt`, `rphase` = 0.
- `vsync_q` resets to 1, so a `vsync` already high at reset release generates no tick until its next rising edge.
- Tick detected in cycle N → all outputs update at the N→N+1 edge. Pulses are high for exactly cycle N+1.
- Latency from a stable `buttons` change to `pressed`: second tick after the change, +1 cycle.
- Reset asserted mid-operation clears everything within one cycle. A button still held afterwards yields a fresh `pressed` two ticks after reset release.
- `buttons` may change any cycle; it is sampled only in tick cycles. No other handshake.

## Configuration
- `GAME_CONTROLLER_AUTOREPEAT_EN` defined:
  - `rcnt`/`rphase` are implemented as above.
- Undefined:
  - The repeat logic is omitted.
  - `repeat_pulse` is tied to 0.
  - `any_event` covers only `pressed | released`.
  - Parameters `REPEAT_*` are accepted but ignored.

## Test plan
- Reset, then `buttons=12'h800` stable: tick 1 → no event; tick 2 → `pressed=12'h800` for one cycle and `held=12'h800`; `any_event=1` in the same cycle.
- `buttons=12'h040` for one frame only (one tick), then 0: `held`, `pressed`, `released` stay 0 throughout.
- From `held=12'h800`, set `buttons=0`: second tick → `released=12'h800` one cycle, `held=0`.
- Macro defined, `REPEAT_DELAY=4`, `REPEAT_RATE=2`: hold `12'h080` with `pressed` at tick k.
  - Expect `repeat_pulse=12'h080` at ticks k+4, k+6, k+8.
  - Add `12'h020` so it debounces in at tick j: expect no repeat at j, next repeat `12'h0A0` at j+4.
- Hold `12'h008` (A) for 30 frames: `repeat_pulse` stays 0. With the macro undefined, repeat the previous scenario: `repeat_pulse` is always 0.
- `vsync` high across reset release: no tick until the next 0→1. Assert reset while `12'h800` is held: outputs go to 0 next cycle, and `pressed=12'h800` reappears on the second tick after release.
